// File: rtl/diagonal_order_monitor_if.sv
// diagonal_order_monitor_if
//    Sample bus from the diagonal X/Y counter pair to its order monitor.
//    Ports (signals):
//       in_valid : X_in/Y_in carry a new sample this cycle
//       X_in     : sampled X (W bits)
//       Y_in     : sampled Y (W bits)
//    Modports: master drives the sample, slave (the monitor) observes it.
interface diagonal_order_monitor_if #(
   parameter int W = 4
);
   logic         in_valid;
   logic [W-1:0] X_in;
   logic [W-1:0] Y_in;

   modport master (output in_valid, output X_in, output Y_in);
   modport slave  (input  in_valid, input  X_in, input  Y_in);
endinterface

// File: rtl/diagonal_order_monitor.sv
// diagonal_order_monitor
//    Observes every (X,Y) sample of the diagonal counter pair and checks X >= Y.
//    Latches the first violating sample, counts steps and X wrap-arounds,
//    tracks the largest X-Y gap and flags runs of identical samples as a stall.
//    Ports:
//       clk        : rising-edge clock
//       reset      : synchronous active-high reset, highest priority
//       smp        : sample bus (in_valid, X_in, Y_in), slave side
//       state      : IDLE=0, TRACK=1, STALL=2, VIOL=3
//       viol       : sticky violation flag
//       viol_x/y   : first violating sample
//       viol_step  : step_cnt at the first violation
//       step_cnt   : accepted samples after the first one (saturating)
//       wrap_cnt   : X wrap-arounds (saturating)
//       max_gap    : largest X-Y over non-violating samples
//       stalled    : high while state==STALL
module diagonal_order_monitor #(
   parameter int W         = 4,
   parameter int CNT_W     = 16,
   parameter int STALL_LIM = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   diagonal_order_monitor_if.slave      smp,
   output logic [1:0]                   state,
   output logic                         viol,
   output logic [W-1:0]                 viol_x,
   output logic [W-1:0]                 viol_y,
   output logic [CNT_W-1:0]             viol_step,
   output logic [CNT_W-1:0]             step_cnt,
   output logic [CNT_W-1:0]             wrap_cnt,
   output logic [W-1:0]                 max_gap,
   output logic                         stalled
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      STALL = 2'd2,
      VIOL  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] STALL_LIM_C = CNT_W'(STALL_LIM);

   state_t           state_reg;
   logic             viol_reg;
   logic [W-1:0]     viol_x_reg, viol_y_reg;
   logic [CNT_W-1:0] viol_step_reg;
   logic [CNT_W-1:0] step_cnt_reg, wrap_cnt_reg, stall_cnt_reg;
   logic [W-1:0]     max_gap_reg;
   logic             stalled_reg;
   logic [W-1:0]     prev_x_reg, prev_y_reg;

   // Formal hook: the harness asserts this stays high.
   logic prop_ok;
   assign prop_ok = ~viol_reg;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Sample classification
   logic             bad, same, wrap;
   logic [W-1:0]     gap;
   logic [CNT_W-1:0] step_next, wrap_next, stall_next;

   assign bad        = smp.X_in < smp.Y_in;
   assign same       = (smp.X_in == prev_x_reg) && (smp.Y_in == prev_y_reg);
   assign wrap       = smp.X_in < prev_x_reg;
   assign gap        = smp.X_in - smp.Y_in;
   assign step_next  = sat_inc(step_cnt_reg);
   assign wrap_next  = wrap ? sat_inc(wrap_cnt_reg) : wrap_cnt_reg;
   assign stall_next = same ? sat_inc(stall_cnt_reg) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         viol_reg      <= 1'b0;
         viol_x_reg    <= '0;
         viol_y_reg    <= '0;
         viol_step_reg <= '0;
         step_cnt_reg  <= '0;
         wrap_cnt_reg  <= '0;
         stall_cnt_reg <= '0;
         max_gap_reg   <= '0;
         stalled_reg   <= 1'b0;
         prev_x_reg    <= '0;
         prev_y_reg    <= '0;
      end else if (smp.in_valid) begin
         case (state_reg)
            IDLE: begin
               // First sample only seeds history: no step, no wrap.
               prev_x_reg  <= smp.X_in;
               prev_y_reg  <= smp.Y_in;
               max_gap_reg <= bad ? '0 : gap;
               if (bad) begin
                  state_reg     <= VIOL;
                  viol_reg      <= 1'b1;
                  viol_x_reg    <= smp.X_in;
                  viol_y_reg    <= smp.Y_in;
                  viol_step_reg <= '0;
               end else begin
                  state_reg <= TRACK;
               end
            end
            TRACK, STALL: begin
               step_cnt_reg  <= step_next;
               wrap_cnt_reg  <= wrap_next;
               stall_cnt_reg <= stall_next;
               prev_x_reg    <= smp.X_in;
               prev_y_reg    <= smp.Y_in;
               if (!bad && gap > max_gap_reg)
                  max_gap_reg <= gap;
               // Violation wins over stall on the same sample.
               if (bad) begin
                  state_reg     <= VIOL;
                  stalled_reg   <= 1'b0;
                  viol_reg      <= 1'b1;
                  viol_x_reg    <= smp.X_in;
                  viol_y_reg    <= smp.Y_in;
                  viol_step_reg <= step_next;
               end else if (state_reg == STALL) begin
                  // Stay stalled on repeats, resume tracking on fresh data.
                  state_reg   <= same ? STALL : TRACK;
                  stalled_reg <= same;
               end else if (stall_next == STALL_LIM_C) begin
                  state_reg   <= STALL;
                  stalled_reg <= 1'b1;
               end
            end
            default: begin
               // VIOL is absorbing until reset.
            end
         endcase
      end
   end

   assign state     = state_reg;
   assign viol      = ~prop_ok;
   assign viol_x    = viol_x_reg;
   assign viol_y    = viol_y_reg;
   assign viol_step = viol_step_reg;
   assign step_cnt  = step_cnt_reg;
   assign wrap_cnt  = wrap_cnt_reg;
   assign max_gap   = max_gap_reg;
   assign stalled   = stalled_reg;

endmodule

// File: tb/tb_diagonal_order_monitor.sv
module tb_diagonal_order_monitor;
   localparam int W = 4;
   localparam int CNT_W = 16;
   localparam int STALL_LIM = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [1:0]       state;
   logic             viol, stalled;
   logic [W-1:0]     viol_x, viol_y, max_gap;
   logic [CNT_W-1:0] viol_step, step_cnt, wrap_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   diagonal_order_monitor_if #(.W(W)) smp ();

   diagonal_order_monitor #(.W(W), .CNT_W(CNT_W), .STALL_LIM(STALL_LIM)) dut (
      .clk       (clk),
      .reset     (reset),
      .smp       (smp.slave),
      .state     (state),
      .viol      (viol),
      .viol_x    (viol_x),
      .viol_y    (viol_y),
      .viol_step (viol_step),
      .step_cnt  (step_cnt),
      .wrap_cnt  (wrap_cnt),
      .max_gap   (max_gap),
      .stalled   (stalled)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one valid sample for one edge; returns on the following negedge.
   task automatic send(input int x, input int y);
      @(negedge clk);
      smp.in_valid = 1'b1;
      smp.X_in = W'(x);
      smp.Y_in = W'(y);
      @(negedge clk);
      smp.in_valid = 1'b0;
      $display("sample (%0d,%0d) -> state=%0d step=%0d wrap=%0d gap=%0d viol=%0d stalled=%0d",
               x, y, state, step_cnt, wrap_cnt, max_gap, viol, stalled);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      $display("reset");
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".state"},     state, 0);
      check({tag, ".viol"},      viol, 0);
      check({tag, ".viol_x"},    viol_x, 0);
      check({tag, ".viol_y"},    viol_y, 0);
      check({tag, ".viol_step"}, viol_step, 0);
      check({tag, ".step"},      step_cnt, 0);
      check({tag, ".wrap"},      wrap_cnt, 0);
      check({tag, ".gap"},       max_gap, 0);
      check({tag, ".stalled"},   stalled, 0);
   endtask

   initial begin
      smp.in_valid = 1'b0;
      smp.X_in = '0;
      smp.Y_in = '0;

      // Reset state
      do_reset();
      check_all_zero("rst");

      // Diagonal walk
      send(0,0); send(1,1); send(2,2); send(3,3);
      check("diag.state", state, 1);
      check("diag.step", step_cnt, 3);
      check("diag.gap", max_gap, 0);
      check("diag.viol", viol, 0);
      check("diag.wrap", wrap_cnt, 0);

      // Wrap-arounds
      do_reset();
      send(0,0); send(15,14); send(14,14); send(15,15); send(0,0);
      check("wrap.wrap", wrap_cnt, 2);
      check("wrap.gap", max_gap, 1);
      check("wrap.step", step_cnt, 4);
      check("wrap.state", state, 1);

      // Violation capture and absorption
      do_reset();
      send(5,2); send(6,8);
      check("viol.state", state, 3);
      check("viol.viol", viol, 1);
      check("viol.x", viol_x, 6);
      check("viol.y", viol_y, 8);
      check("viol.step", viol_step, 1);
      check("viol.gap", max_gap, 3);
      send(9,1);
      check("viol.hold.x", viol_x, 6);
      check("viol.hold.step", step_cnt, 1);
      check("viol.hold.gap", max_gap, 3);
      check("viol.hold.state", state, 3);

      // Bad first sample in IDLE
      do_reset();
      send(1,3);
      check("idlebad.state", state, 3);
      check("idlebad.step", viol_step, 0);
      check("idlebad.x", viol_x, 1);

      // Stall detection and recovery
      do_reset();
      send(7,3);
      for (int i = 1; i <= STALL_LIM; i++) begin
         send(7,3);
         if (i == STALL_LIM - 1) check("stall.pre", stalled, 0);
      end
      check("stall.stalled", stalled, 1);
      check("stall.state", state, 2);
      send(7,3);
      check("stall.stay", state, 2);
      send(8,3);
      check("stall.resume.state", state, 1);
      check("stall.resume.stalled", stalled, 0);
      check("stall.resume.step", step_cnt, 10);
      check("stall.resume.gap", max_gap, 5);

      // Violation out of STALL, then reset clears everything
      do_reset();
      send(7,3);
      for (int i = 0; i < STALL_LIM; i++) send(7,3);
      check("sv.pre", state, 2);
      send(2,4);
      check("sv.state", state, 3);
      check("sv.stalled", stalled, 0);
      check("sv.viol", viol, 1);
      check("sv.step", viol_step, 9);
      do_reset();
      check_all_zero("sv.rst");

      // Idle cycles leave state alone; reset beats a bad valid sample
      send(4,1);
      repeat (3) @(negedge clk);
      check("idle.state", state, 1);
      check("idle.step", step_cnt, 0);
      send(5,1);
      repeat (2) @(negedge clk);
      check("idle.step2", step_cnt, 1);
      check("idle.gap", max_gap, 4);
      @(negedge clk);
      reset = 1'b1;
      smp.in_valid = 1'b1;
      smp.X_in = 4'd2;
      smp.Y_in = 4'd5;
      @(negedge clk);
      reset = 1'b0;
      smp.in_valid = 1'b0;
      $display("reset with bad sample (2,5)");
      check_all_zero("rstwin");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/diagonal_order_monitor.md
Name: diagonal_order_monitor

Overview:
- Downstream observer for the diagonal X/Y counter pair. Samples each (X,Y) the counter produces and checks the ordering invariant X >= Y.
- Captures the first violation, tracks progress statistics (steps, X wrap-arounds, largest X-Y gap) and detects stalls.
- Exposes a sticky `viol` flag for the formal harness to assert against, plus debug state for simulation benches.

Parameters:
- W, 4, data width of X and Y (Kmax = 2^W-1).
- CNT_W, 16, width of the step and wrap counters.
- STALL_LIM, 8, number of consecutive repeated (X,Y) samples that declares a stall (>=1).

Ports:
- clk  input  1  rising-edge clock, same domain as the counter pair.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  X_in/Y_in hold a new sample this cycle.
- X_in  input  W  sampled X.
- Y_in  input  W  sampled Y.
- state  output  2  FSM state: IDLE=0, TRACK=1, STALL=2, VIOL=3.
- viol  output  1  sticky: a sample with X_in < Y_in was seen.
- viol_x  output  W  X of the first violating sample.
- viol_y  output  W  Y of the first violating sample.
- viol_step  output  CNT_W  step_cnt value at the first violation.
- step_cnt  output  CNT_W  accepted samples after the first one, saturating.
- wrap_cnt  output  CNT_W  X wrap-arounds, saturating.
- max_gap  output  W  largest X_in-Y_in seen over samples with X_in >= Y_in.
- stalled  output  1  high exactly while state==STALL.

Behaviour:
- All outputs are registered and update on the clk edge that samples in_valid=1, so a sample's effect is visible the next cycle.
- in_valid=0 in any state: no register changes.
- Reset has priority over everything. On the edge with reset=1:
  - state=IDLE;
  - viol, viol_x, viol_y, viol_step, step_cnt, wrap_cnt, max_gap, stalled all become 0;
  - internal prev_x, prev_y and stall_cnt are cleared.
- Reset asserted mid-operation discards all history, including a latched violation.
- Internal state: prev_x/prev_y hold the last accepted sample; stall_cnt is CNT_W wide and saturating.
- Sample classification:
  - bad = X_in < Y_in (unsigned);
  - same = (X_in==prev_x && Y_in==prev_y);
  - wrap = X_in < prev_x;
  - gap = X_in-Y_in, W bits, meaningful only when !bad.
- IDLE, on a valid sample:
  - load prev; max_gap = bad ? 0 : gap;
  - step_cnt stays 0 and no wrap is counted;
  - if bad, go to VIOL and capture viol_x=X_in, viol_y=Y_in, viol_step=0; otherwise go to TRACK.
- TRACK, on a valid sample:
  - step_cnt+1 (saturating); wrap_cnt+1 if wrap (saturating); load prev;
  - if !bad and gap > max_gap, update max_gap;
  - if same, stall_cnt+1, else stall_cnt=0.
  - Transition priority: bad -> VIOL, capturing X_in, Y_in and the post-increment step_cnt; else if the incremented stall_cnt == STALL_LIM -> STALL; else stay in TRACK.
- STALL:
  - Same updates as TRACK.
  - A non-same, non-bad sample clears stall_cnt and returns to TRACK.
  - A bad sample goes to VIOL.
  - A same sample stays in STALL.
- VIOL:
  - Absorbing until reset. All counters, max_gap and prev freeze; viol=1 and the capture registers hold.
- Violation beats stall when both occur on the same sample.
- Counter saturation: step_cnt, wrap_cnt and stall_cnt hold at 2^CNT_W-1; they never wrap.
- Formal hook: `prop_ok = !viol` is provided as an internal wire for the harness assertion.

Test Plan:
- Reset, then valid samples (0,0),(1,1),(2,2),(3,3) -> state TRACK, step_cnt=3, max_gap=0, viol=0, wrap_cnt=0.
- W=4, samples (0,0),(15,14),(14,14),(15,15),(0,0) -> wrap_cnt=1 (X 15->0); (15,14)->(14,14) also counts, so wrap_cnt=2 overall; max_gap=1, step_cnt=4.
- Samples (5,2),(6,8),(9,1) -> VIOL after the second sample: viol_x=6, viol_y=8, viol_step=1, max_gap=3; the third sample changes nothing.
- STALL_LIM=8, sample (7,3), then (7,3) repeated 8 times -> stalled=1 on the cycle after the 8th repeat; then (8,3) -> TRACK, stalled=0, step_cnt=9.
- In STALL, sample (2,4) -> VIOL, stalled=0, viol=1; then assert reset for 1 cycle -> all outputs 0, state IDLE.
- Valid samples interleaved with in_valid=0 cycles, and reset asserted together with in_valid=1 carrying a bad pair -> idle cycles leave state unchanged; reset wins, viol=0.
